// File: rtl/guess_game_ctrl.sv
// Number-guessing game controller. Latches the secret onto the comparator's
// B input and each guess onto its A input. It evaluates the comparator flags
// one cycle later and tracks attempts, hints and the remaining search window.
module guess_game_ctrl #(
  parameter int unsigned MAX_TRIES = 7  // attempts per game, 1..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] seed_in,
  input  logic       guess_valid,
  input  logic [7:0] guess,
  input  logic       AGTB,
  input  logic       AEQB,
  input  logic       ALTB,
  output logic [7:0] A,
  output logic [7:0] B,
  output logic       busy,
  output logic       hint_hi,
  output logic       hint_lo,
  output logic       win,
  output logic       lose,
  output logic       err,
  output logic [3:0] tries,
  output logic [7:0] lower_bound,
  output logic [7:0] upper_bound
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_CHECK,
    S_WIN,
    S_LOSE,
    S_ERR
  } state_t;

  localparam logic [3:0] MAX_TRIES_L = 4'(MAX_TRIES);

  state_t     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] lo_q, lo_d;
  logic [7:0] up_q, up_d;
  logic [3:0] tries_q, tries_d;
  logic       hint_hi_q, hint_hi_d;
  logic       hint_lo_q, hint_lo_d;

  logic       flags_onehot;
  logic [7:0] a_minus_1;
  logic [7:0] a_plus_1;
  logic [3:0] tries_inc;

  // Comparator sanity check and the candidate narrowed bounds.
  always_comb begin
    flags_onehot = ({AGTB, AEQB, ALTB} == 3'b100) ||
                   ({AGTB, AEQB, ALTB} == 3'b010) ||
                   ({AGTB, AEQB, ALTB} == 3'b001);
    a_minus_1    = a_q - 8'd1;
    a_plus_1     = a_q + 8'd1;
    tries_inc    = tries_q + 4'd1;
  end

  // Next-state and datapath updates; start overrides everything else.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    lo_d      = lo_q;
    up_d      = up_q;
    tries_d   = tries_q;
    hint_hi_d = hint_hi_q;
    hint_lo_d = hint_lo_q;

    case (state_q)
      S_PLAY: begin
        if (guess_valid) begin
          a_d     = guess;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        tries_d = tries_inc;
        if (!flags_onehot) begin
          // Broken comparator: freeze hints and bounds, park in ERR.
          state_d = S_ERR;
        end else if (AEQB) begin
          hint_hi_d = 1'b0;
          hint_lo_d = 1'b0;
          state_d   = S_WIN;
        end else begin
          if (AGTB) begin
            hint_hi_d = 1'b1;
            hint_lo_d = 1'b0;
            if (a_minus_1 < up_q) up_d = a_minus_1;
          end else begin
            hint_hi_d = 1'b0;
            hint_lo_d = 1'b1;
            if (a_plus_1 > lo_q) lo_d = a_plus_1;
          end
          state_d = (tries_inc == MAX_TRIES_L) ? S_LOSE : S_PLAY;
        end
      end
      default: ;
    endcase

    if (start) begin
      state_d   = S_PLAY;
      a_d       = 8'd0;
      b_d       = seed_in;
      lo_d      = 8'd0;
      up_d      = 8'hFF;
      tries_d   = 4'd0;
      hint_hi_d = 1'b0;
      hint_lo_d = 1'b0;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= 8'd0;
      b_q       <= 8'd0;
      lo_q      <= 8'd0;
      up_q      <= 8'hFF;
      tries_q   <= 4'd0;
      hint_hi_q <= 1'b0;
      hint_lo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      lo_q      <= lo_d;
      up_q      <= up_d;
      tries_q   <= tries_d;
      hint_hi_q <= hint_hi_d;
      hint_lo_q <= hint_lo_d;
    end
  end

  assign A           = a_q;
  assign B           = b_q;
  assign busy        = (state_q == S_PLAY) || (state_q == S_CHECK);
  assign win         = (state_q == S_WIN);
  assign lose        = (state_q == S_LOSE);
  assign err         = (state_q == S_ERR);
  assign hint_hi     = hint_hi_q;
  assign hint_lo     = hint_lo_q;
  assign tries       = tries_q;
  assign lower_bound = lo_q;
  assign upper_bound = up_q;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Bench for guess_game_ctrl: directed game scenarios plus random games, all
// checked against a game-rule model. A behavioural comparator closes the loop
// and can be overridden to inject illegal flag combinations.
module tb_guess_game_ctrl;

  localparam int MT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] seed_in = 8'd0;
  logic       guess_valid = 1'b0;
  logic [7:0] guess = 8'd0;
  logic       AGTB, AEQB, ALTB;
  logic [7:0] A, B;
  logic       busy, hint_hi, hint_lo, win, lose, err;
  logic [3:0] tries;
  logic [7:0] lower_bound, upper_bound;

  logic       ovr_en = 1'b0;
  logic [2:0] ovr_flags = 3'b000;

  int n_checks = 0;
  int n_fail   = 0;

  // Game model: phase 0 idle, 1 playing, 2 won, 3 lost, 4 error.
  int m_phase, m_sec, m_a, m_tries, m_lo, m_up;
  bit m_hh, m_hl;

  guess_game_ctrl #(.MAX_TRIES(MT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed_in(seed_in),
    .guess_valid(guess_valid), .guess(guess),
    .AGTB(AGTB), .AEQB(AEQB), .ALTB(ALTB),
    .A(A), .B(B), .busy(busy), .hint_hi(hint_hi), .hint_lo(hint_lo),
    .win(win), .lose(lose), .err(err), .tries(tries),
    .lower_bound(lower_bound), .upper_bound(upper_bound)
  );

  always #5 clk = ~clk;

  // Combinational comparator, optionally overridden with forced flags.
  always_comb begin
    if (ovr_en) begin
      {AGTB, AEQB, ALTB} = ovr_flags;
    end else begin
      AGTB = (A > B);
      AEQB = (A == B);
      ALTB = (A < B);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_sec = 0; m_a = 0; m_tries = 0; m_lo = 0; m_up = 255;
    m_hh = 0; m_hl = 0;
  endtask

  task automatic model_start(input int s);
    m_phase = 1; m_sec = s; m_a = 0; m_tries = 0; m_lo = 0; m_up = 255;
    m_hh = 0; m_hl = 0;
  endtask

  task automatic model_guess(input int g, input bit bad);
    if (m_phase != 1) return;
    m_a = g;
    m_tries++;
    if (bad) begin
      m_phase = 4;
    end else if (g == m_sec) begin
      m_phase = 2; m_hh = 0; m_hl = 0;
    end else begin
      if (g > m_sec) begin
        m_hh = 1; m_hl = 0;
        if (g - 1 < m_up) m_up = g - 1;
      end else begin
        m_hh = 0; m_hl = 1;
        if (g + 1 > m_lo) m_lo = g + 1;
      end
      if (m_tries == MT) m_phase = 3;
    end
  endtask

  task automatic check_all(input string ctx);
    check_eq({ctx, ".A"}, 32'(A), 32'(m_a));
    check_eq({ctx, ".B"}, 32'(B), 32'(m_sec));
    check_eq({ctx, ".busy"}, 32'(busy), 32'(m_phase == 1));
    check_eq({ctx, ".hint_hi"}, 32'(hint_hi), 32'(m_hh));
    check_eq({ctx, ".hint_lo"}, 32'(hint_lo), 32'(m_hl));
    check_eq({ctx, ".win"}, 32'(win), 32'(m_phase == 2));
    check_eq({ctx, ".lose"}, 32'(lose), 32'(m_phase == 3));
    check_eq({ctx, ".err"}, 32'(err), 32'(m_phase == 4));
    check_eq({ctx, ".tries"}, 32'(tries), 32'(m_tries));
    check_eq({ctx, ".lower"}, 32'(lower_bound), 32'(m_lo));
    check_eq({ctx, ".upper"}, 32'(upper_bound), 32'(m_up));
  endtask

  // Entered and left at a falling edge. with_guess also raises guess_valid.
  task automatic do_start(input logic [7:0] s, input bit with_guess);
    start = 1'b1; seed_in = s;
    guess_valid = with_guess; guess = 8'd77;
    @(negedge clk);
    start = 1'b0; guess_valid = 1'b0;
    model_start(s);
    $display("start seed=%0d with_guess=%0d -> busy=%0d B=%0d tries=%0d",
             s, with_guess, busy, B, tries);
    check_all("start");
  endtask

  // One guess: pulse, then the CHECK cycle. extra keeps guess_valid high
  // through CHECK (must be dropped); bad forces illegal comparator flags.
  task automatic do_guess(input logic [7:0] g, input bit extra,
                          input bit bad, input logic [2:0] bad_flags);
    bit playing;
    playing = (m_phase == 1);
    guess_valid = 1'b1; guess = g;
    @(negedge clk);
    guess_valid = extra; guess = ~g;
    ovr_en = bad; ovr_flags = bad_flags;
    check_eq("check.A", 32'(A), playing ? 32'(g) : 32'(m_a));
    check_eq("check.busy", 32'(busy), 32'(playing));
    @(negedge clk);
    guess_valid = 1'b0; ovr_en = 1'b0;
    model_guess(g, bad);
    $display("guess=%0d extra=%0d bad=%0d -> tries=%0d lo=%0d up=%0d hh=%0d hl=%0d w/l/e=%0d%0d%0d",
             g, extra, bad, tries, lower_bound, upper_bound, hint_hi, hint_lo,
             win, lose, err);
    check_all("guess");
  endtask

  initial begin
    int g;
    logic [2:0] bad_tab [5];
    bad_tab[0] = 3'b000; bad_tab[1] = 3'b011; bad_tab[2] = 3'b101;
    bad_tab[3] = 3'b110; bad_tab[4] = 3'b111;

    // Reset state.
    model_reset();
    @(negedge clk); @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all("idle");

    // Guess in IDLE is ignored.
    do_guess(8'd9, 1'b0, 1'b0, 3'b000);

    // Win on final attempt: 50, 150, 100 against secret 100.
    do_start(8'd100, 1'b0);
    do_guess(8'd50, 1'b0, 1'b0, 3'b000);
    do_guess(8'd150, 1'b0, 1'b0, 3'b000);
    do_guess(8'd100, 1'b0, 1'b0, 3'b000);

    // Lose: secret 7, guesses 200, 1, 9 -> bounds 2/8, then a dead guess.
    do_start(8'd7, 1'b0);
    do_guess(8'd200, 1'b0, 1'b0, 3'b000);
    do_guess(8'd1, 1'b0, 1'b0, 3'b000);
    do_guess(8'd9, 1'b0, 1'b0, 3'b000);
    do_guess(8'd7, 1'b0, 1'b0, 3'b000);

    // Guess during CHECK dropped; start beats guess_valid.
    do_start(8'd40, 1'b0);
    do_guess(8'd10, 1'b1, 1'b0, 3'b000);
    do_start(8'd41, 1'b1);
    do_guess(8'd41, 1'b0, 1'b0, 3'b000);

    // Illegal flags -> ERR with bounds frozen; start recovers.
    do_start(8'd60, 1'b0);
    do_guess(8'd30, 1'b0, 1'b0, 3'b000);
    do_guess(8'd90, 1'b0, 1'b1, 3'b110);
    do_guess(8'd60, 1'b0, 1'b0, 3'b000);
    do_start(8'd60, 1'b0);

    // Asynchronous reset in the middle of CHECK.
    guess_valid = 1'b1; guess = 8'd12;
    @(negedge clk);
    guess_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    $display("async reset mid-CHECK -> busy=%0d A=%0d B=%0d", busy, A, B);
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all("post_rst");

    // Random games.
    for (int game = 0; game < 25; game++) begin
      do_start(8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) == 0));
      for (int k = 0; k < MT + 1; k++) begin
        if ($urandom_range(0, 1) == 1) g = (m_lo + m_up) / 2;
        else g = $urandom_range(0, 255);
        if ($urandom_range(0, 9) == 0)
          do_guess(8'(g), 1'b0, 1'b1, bad_tab[$urandom_range(0, 4)]);
        else
          do_guess(8'(g), 1'($urandom_range(0, 3) == 0), 1'b0, 3'b000);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
